instr_encoder: RTL

- Inverse of the core's immediate decode path: accepts a t_opcode, register fields, funct fields and a signed 32-bit immediate.
- Range- and alignment-checks the immediate, packs it into the opcode's RISC-V instruction format and writes the word into instruction memory at an auto-incrementing address.
- Used as a program loader / self-test generator in front of the instruction memory; output words must decode back to the same immediate in the decode stage.

---
 rtl/instr_encoder.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// Instruction encoder: range/alignment-checks an immediate, packs it into its
// RISC-V format and writes the word to instruction memory at an auto-incrementing address.
package instr_encoder_pkg;
  localparam int DATA_SIZE = 32;
  localparam int INST_SIZE = 32;

  typedef enum logic [6:0] {
    LOADS    = 7'b0000011,
    ALC_I    = 7'b0010011,
    AUIPC    = 7'b0010111,
    STORES   = 7'b0100011,
    ALC_R    = 7'b0110011,
    LUI      = 7'b0110111,
    BRANCHES = 7'b1100011,
    JALR     = 7'b1100111,
    JAL      = 7'b1101111
  } t_opcode;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_ALIGN = 2'b10;
  localparam logic [1:0] ERR_OP    = 2'b11;

  typedef struct packed {
    logic [1:0]           err;
    logic [INST_SIZE-1:0] word;
  } enc_t;
endpackage

module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h0000_0000)
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  t_opcode                     i_op,
  input  logic [4:0]                  i_rd,
  input  logic [4:0]                  i_rs1,
  input  logic [4:0]                  i_rs2,
  input  logic [2:0]                  i_funct3,
  input  logic [6:0]                  i_funct7,
  input  logic signed [DATA_SIZE-1:0] i_immediate,
  input  logic                        i_start,
  output logic                        o_mem_we,
  output logic [ADDR_WIDTH-1:0]       o_mem_addr,
  output logic [INST_SIZE-1:0]        o_mem_wdata,
  input  logic                        i_mem_ack,
  output logic                        o_err,
  output logic [1:0]                  o_err_code,
  output logic [15:0]                 o_count
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WRITE, S_ERR} state_t;

  state_t                  state_r, state_nxt;
  t_opcode                 op_r;
  logic [4:0]              rd_r, rs1_r, rs2_r;
  logic [2:0]              f3_r;
  logic [6:0]              f7_r;
  logic signed [31:0]      imm_r;
  logic                    ready_r, we_r, err_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [INST_SIZE-1:0]    wdata_r;
  logic [1:0]              err_code_r;
  logic [15:0]             count_r;
  enc_t                    enc_s;

  function automatic logic in_range(input logic signed [31:0] v,
                                    input logic signed [31:0] lo,
                                    input logic signed [31:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // Error precedence: unsupported opcode, then range, then alignment.
  function automatic enc_t encode(input t_opcode op, input logic [4:0] rd,
                                  input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic [2:0] f3, input logic [6:0] f7,
                                  input logic signed [31:0] imm);
    enc_t e;
    e.err  = ERR_NONE;
    e.word = 32'h0000_0000;
    case (op)
      LOADS, JALR: begin
        e.word = {imm[11:0], rs1, f3, rd, op};
        if (!in_range(imm, -32'sd2048, 32'sd2047)) e.err = ERR_RANGE;
        else e.err = ERR_NONE;
      end
      STORES: begin
        e.word = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        if (!in_range(imm, -32'sd2048, 32'sd2047)) e.err = ERR_RANGE;
        else e.err = ERR_NONE;
      end
      ALC_I: begin
        if ((f3 == 3'b001) || (f3 == 3'b101)) begin
          e.word = {f7, imm[4:0], rs1, f3, rd, op};
          if (!in_range(imm, 32'sd0, 32'sd31)) e.err = ERR_RANGE;
          else e.err = ERR_NONE;
        end else begin
          e.word = {imm[11:0], rs1, f3, rd, op};
          if (!in_range(imm, -32'sd2048, 32'sd2047)) e.err = ERR_RANGE;
          else e.err = ERR_NONE;
        end
      end
      BRANCHES: begin
        e.word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        if (!in_range(imm, -32'sd4096, 32'sd4094)) e.err = ERR_RANGE;
        else if (imm[0]) e.err = ERR_ALIGN;
        else e.err = ERR_NONE;
      end
      JAL: begin
        e.word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        if (!in_range(imm, -32'sd1048576, 32'sd1048574)) e.err = ERR_RANGE;
        else if (imm[0]) e.err = ERR_ALIGN;
        else e.err = ERR_NONE;
      end
      LUI, AUIPC: begin
        e.word = {imm[31:12], rd, op};
        if (imm[11:0] != 12'h000) e.err = ERR_ALIGN;
        else e.err = ERR_NONE;
      end
      ALC_R: begin
        e.word = {f7, rs2, rs1, f3, rd, op};
        e.err  = ERR_NONE;
      end
      default: begin
        e.word = 32'h0000_0000;
        e.err  = ERR_OP;
      end
    endcase
    return e;
  endfunction

  // Encoder over the captured request.
  always_comb begin
    enc_s = encode(op_r, rd_r, rs1_r, rs2_r, f3_r, f7_r, imm_r);
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_r <= S_IDLE;
    else          state_r <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_r;
    case (state_r)
      S_IDLE: begin
        if (i_valid) state_nxt = S_CHECK;
        else         state_nxt = S_IDLE;
      end
      S_CHECK: begin
        if (enc_s.err != ERR_NONE) state_nxt = S_ERR;
        else                       state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (i_mem_ack) state_nxt = S_IDLE;
        else           state_nxt = S_WRITE;
      end
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Request capture and registered memory/status outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      op_r       <= LOADS;
      rd_r       <= 5'd0;
      rs1_r      <= 5'd0;
      rs2_r      <= 5'd0;
      f3_r       <= 3'd0;
      f7_r       <= 7'd0;
      imm_r      <= 32'sd0;
      ready_r    <= 1'b1;
      we_r       <= 1'b0;
      err_r      <= 1'b0;
      addr_r     <= BASE_ADDR;
      wdata_r    <= 32'h0000_0000;
      err_code_r <= ERR_NONE;
      count_r    <= 16'd0;
    end else begin
      ready_r <= (state_nxt == S_IDLE);
      err_r   <= (state_nxt == S_ERR);
      case (state_r)
        S_IDLE: begin
          // A start on the accept edge still lands the write at BASE_ADDR.
          if (i_start) addr_r <= BASE_ADDR;
          if (i_valid) begin
            op_r  <= i_op;
            rd_r  <= i_rd;
            rs1_r <= i_rs1;
            rs2_r <= i_rs2;
            f3_r  <= i_funct3;
            f7_r  <= i_funct7;
            imm_r <= i_immediate;
          end
        end
        S_CHECK: begin
          if (enc_s.err != ERR_NONE) begin
            err_code_r <= enc_s.err;
          end else begin
            we_r    <= 1'b1;
            wdata_r <= enc_s.word;
          end
        end
        S_WRITE: begin
          if (i_mem_ack) begin
            we_r    <= 1'b0;
            addr_r  <= addr_r + ADDR_WIDTH'(32'd4);
            count_r <= count_r + 16'd1;
          end
        end
        default: begin
          we_r <= 1'b0;
        end
      endcase
    end
  end

  assign o_ready     = ready_r;
  assign o_mem_we    = we_r;
  assign o_mem_addr  = addr_r;
  assign o_mem_wdata = wdata_r;
  assign o_err       = err_r;
  assign o_err_code  = err_code_r;
  assign o_count     = count_r;

endmodule
